// File: rtl/cart_mem_arbiter_if.sv
// Bundle of CPU/PPU read ports, loader write port and the shared RAM port
// around cart_mem_arbiter; slave is the arbiter's view, master the surroundings.
interface cart_mem_arbiter_if;
    localparam int unsigned AW     = 16;
    localparam int unsigned DW     = 8;
    localparam int unsigned PPU_AW = 14;

    logic              cpu_req;
    logic [AW-1:0]     cpu_addr;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DW-1:0]     cpu_rdata;

    logic              ppu_req;
    logic [PPU_AW-1:0] ppu_addr;
    logic              ppu_gnt;
    logic              ppu_rvalid;
    logic [DW-1:0]     ppu_rdata;

    logic              load_req;
    logic              load_ack;
    logic              ldr_wren;
    logic [AW-1:0]     ldr_addr;
    logic [DW-1:0]     ldr_wdata;
    logic [AW-1:0]     ldr_count;
    logic              cpu_hold;

    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_rden;
    logic              mem_wren;
    logic [DW-1:0]     mem_rdata;

    modport slave (
        input  cpu_req, cpu_addr, ppu_req, ppu_addr,
        input  load_req, ldr_wren, ldr_addr, ldr_wdata, mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, ppu_gnt, ppu_rvalid, ppu_rdata,
        output load_ack, ldr_count, cpu_hold,
        output mem_addr, mem_wdata, mem_rden, mem_wren
    );

    modport master (
        output cpu_req, cpu_addr, ppu_req, ppu_addr,
        output load_req, ldr_wren, ldr_addr, ldr_wdata, mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, ppu_gnt, ppu_rvalid, ppu_rdata,
        input  load_ack, ldr_count, cpu_hold,
        input  mem_addr, mem_wdata, mem_rden, mem_wren
    );
endinterface

// File: rtl/cart_mem_arbiter.sv
// Owns the single cartridge RAM port: round-robin CPU/PPU reads in RUN,
// exclusive loader writes in LOAD, with a one-cycle DRAIN between them.
module cart_mem_arbiter #(
    parameter logic [15:0] PRG_BASE = 16'h0000,
    parameter logic [15:0] CHR_BASE = 16'h8000
) (
    input logic               clk,
    input logic               reset,
    cart_mem_arbiter_if.slave bus
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_ppu;
    logic          cpu_sel;
    logic          ppu_sel;
    logic          cpu_map;
    logic          ppu_map;
    logic          rden;
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          cpu_rvalid_q;
    logic          ppu_rvalid_q;
    logic          cpu_rd_q;
    logic          ppu_rd_q;
    logic [AW-1:0] ldr_count_q;

    // Next state, arbitration and RAM port; everything is forced idle while reset is high
    always_comb begin
        state_nxt = state;
        cpu_sel   = 1'b0;
        ppu_sel   = 1'b0;
        rden      = 1'b0;
        wren      = 1'b0;
        addr      = '0;
        wdata     = '0;
        cpu_map   = bus.cpu_addr[15];
        ppu_map   = ~bus.ppu_addr[13];
        case (state)
            RUN: begin
                if (bus.load_req) begin
                    state_nxt = DRAIN;
                end else begin
                    cpu_sel = bus.cpu_req & (~bus.ppu_req | last_ppu);
                    ppu_sel = bus.ppu_req & ~cpu_sel;
                    if (cpu_sel) begin
                        addr = PRG_BASE + AW'({1'b0, bus.cpu_addr[14:0]});
                        rden = cpu_map;
                    end else if (ppu_sel) begin
                        addr = CHR_BASE + AW'(bus.ppu_addr[12:0]);
                        rden = ppu_map;
                    end
                end
            end
            DRAIN: state_nxt = LOAD;
            LOAD: begin
                wren  = bus.ldr_wren;
                addr  = bus.ldr_addr;
                wdata = bus.ldr_wdata;
                if (!bus.load_req) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        if (reset) begin
            cpu_sel = 1'b0;
            ppu_sel = 1'b0;
            rden    = 1'b0;
            wren    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            last_ppu     <= 1'b1;
            cpu_rvalid_q <= 1'b0;
            ppu_rvalid_q <= 1'b0;
            cpu_rd_q     <= 1'b0;
            ppu_rd_q     <= 1'b0;
            ldr_count_q  <= '0;
        end else begin
            state        <= state_nxt;
            cpu_rvalid_q <= cpu_sel;
            ppu_rvalid_q <= ppu_sel;
            cpu_rd_q     <= cpu_sel & cpu_map;
            ppu_rd_q     <= ppu_sel & ppu_map;
            if (cpu_sel)      last_ppu <= 1'b0;
            else if (ppu_sel) last_ppu <= 1'b1;
            if (state == DRAIN) ldr_count_q <= '0;
            else if (wren)      ldr_count_q <= ldr_count_q + AW'(1);
        end
    end

    assign bus.cpu_gnt    = cpu_sel;
    assign bus.ppu_gnt    = ppu_sel;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.ppu_rvalid = ppu_rvalid_q;
    // RAM data lands in the rvalid cycle; unmapped reads return zero
    assign bus.cpu_rdata  = cpu_rd_q ? bus.mem_rdata : DW'(0);
    assign bus.ppu_rdata  = ppu_rd_q ? bus.mem_rdata : DW'(0);
    assign bus.load_ack   = (state == LOAD);
    assign bus.cpu_hold   = (state != RUN);
    assign bus.ldr_count  = ldr_count_q;
    assign bus.mem_addr   = addr;
    assign bus.mem_wdata  = wdata;
    assign bus.mem_rden   = rden;
    assign bus.mem_wren   = wren;
endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Bench for cart_mem_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model and a shadow memory.
module tb_cart_mem_arbiter;
    localparam logic [15:0] PRG_BASE = 16'h0000;
    localparam logic [15:0] CHR_BASE = 16'h8000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    cart_mem_arbiter_if bus ();

    cart_mem_arbiter #(.PRG_BASE(PRG_BASE), .CHR_BASE(CHR_BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    always @(posedge clk) begin
        if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rden) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Reference model state: mode 0 = reads, 1 = drain, 2 = load
    int          m_mode;
    bit          m_last_ppu;
    bit          m_pc_v, m_pp_v;
    logic [7:0]  m_pc_d, m_pp_d;
    logic [15:0] m_count;

    bit          e_cpu_gnt, e_ppu_gnt, e_rden, e_wren, e_ack, e_hold;
    bit          e_cpu_rvalid, e_ppu_rvalid;
    logic [7:0]  e_cpu_rdata, e_ppu_rdata, e_wdata, e_next_d;
    logic [15:0] e_addr, e_count;

    task automatic model_eval();
        e_cpu_gnt = 0; e_ppu_gnt = 0; e_rden = 0; e_wren = 0;
        e_addr = 16'h0; e_wdata = 8'h00; e_next_d = 8'h00;
        e_cpu_rvalid = m_pc_v; e_cpu_rdata = m_pc_v ? m_pc_d : 8'h00;
        e_ppu_rvalid = m_pp_v; e_ppu_rdata = m_pp_v ? m_pp_d : 8'h00;
        e_ack = (m_mode == 2); e_hold = (m_mode != 0); e_count = m_count;
        if (!reset) begin
            if (m_mode == 0 && !bus.load_req) begin
                if (bus.cpu_req && bus.ppu_req) begin
                    e_cpu_gnt = m_last_ppu; e_ppu_gnt = !m_last_ppu;
                end else begin
                    e_cpu_gnt = bus.cpu_req; e_ppu_gnt = bus.ppu_req;
                end
                if (e_cpu_gnt) begin
                    e_rden = (bus.cpu_addr >= 16'h8000);
                    e_addr = PRG_BASE + (bus.cpu_addr - 16'h8000);
                end
                if (e_ppu_gnt) begin
                    e_rden = (bus.ppu_addr < 14'h2000);
                    e_addr = CHR_BASE + 16'(bus.ppu_addr);
                end
                e_next_d = e_rden ? ref_mem[e_addr] : 8'h00;
            end else if (m_mode == 2) begin
                e_wren = bus.ldr_wren; e_addr = bus.ldr_addr; e_wdata = bus.ldr_wdata;
            end
        end
    endtask

    task automatic model_commit();
        if (reset) begin
            m_mode = 0; m_last_ppu = 1; m_pc_v = 0; m_pp_v = 0; m_count = 16'h0;
        end else begin
            m_pc_v = e_cpu_gnt; m_pc_d = e_next_d;
            m_pp_v = e_ppu_gnt; m_pp_d = e_next_d;
            if (e_cpu_gnt) m_last_ppu = 0;
            if (e_ppu_gnt) m_last_ppu = 1;
            if (e_wren) begin ref_mem[e_addr] = e_wdata; m_count = m_count + 16'h1; end
            case (m_mode)
                0: if (bus.load_req) m_mode = 1;
                1: begin m_mode = 2; m_count = 16'h0; end
                default: if (!bus.load_req) m_mode = 0;
            endcase
        end
    endtask

    task automatic idle();
        bus.cpu_req = 0; bus.cpu_addr = 16'h0; bus.ppu_req = 0; bus.ppu_addr = 14'h0;
        bus.load_req = 0; bus.ldr_wren = 0; bus.ldr_addr = 16'h0; bus.ldr_wdata = 8'h00;
    endtask

    task automatic settle();
        model_eval();
        @(negedge clk);
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle(); reset = 1; settle(); advance(); reset = 0;
    endtask

    task automatic test_reset();
        idle(); settle();
        checks++; if (bus.cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_cpu_gnt got %b exp 0", bus.cpu_gnt); end
        checks++; if (bus.ppu_gnt !== 1'b0) begin errors++; $display("FAIL reset_ppu_gnt got %b exp 0", bus.ppu_gnt); end
        checks++; if (bus.cpu_rvalid !== 1'b0 || bus.ppu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b%b exp 00", bus.cpu_rvalid, bus.ppu_rvalid); end
        checks++; if (bus.cpu_rdata !== 8'h00 || bus.ppu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h/%h exp 00/00", bus.cpu_rdata, bus.ppu_rdata); end
        checks++; if (bus.load_ack !== 1'b0 || bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_ack_hold got %b%b exp 00", bus.load_ack, bus.cpu_hold); end
        checks++; if (bus.ldr_count !== 16'h0) begin errors++; $display("FAIL reset_count got %h exp 0000", bus.ldr_count); end
        checks++; if (bus.mem_rden !== 1'b0 || bus.mem_wren !== 1'b0) begin errors++; $display("FAIL reset_mem_ctl got %b%b exp 00", bus.mem_rden, bus.mem_wren); end
        advance();
    endtask

    task automatic test_single_read();
        idle(); bus.cpu_req = 1; bus.cpu_addr = 16'hFFFC; settle();
        checks++; if (bus.cpu_gnt !== 1'b1 || bus.mem_rden !== 1'b1) begin errors++; $display("FAIL single_gnt got gnt=%b rden=%b exp 1/1", bus.cpu_gnt, bus.mem_rden); end
        checks++; if (bus.mem_addr !== 16'h7FFC) begin errors++; $display("FAIL single_addr got %h exp 7ffc", bus.mem_addr); end
        advance();
        idle(); settle();
        checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h34) begin errors++; $display("FAIL single_data got v=%b d=%h exp 1/34", bus.cpu_rvalid, bus.cpu_rdata); end
        advance();
    endtask

    task automatic test_alternate();
        bit cpu_win;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i < 4) begin
                bus.cpu_req = 1; bus.cpu_addr = 16'h8010 + 16'(i);
                bus.ppu_req = 1; bus.ppu_addr = 14'h0100 + 14'(i);
            end
            settle();
            cpu_win = (i % 2 == 0);
            if (i < 4) begin
                checks++; if (bus.cpu_gnt !== cpu_win || bus.ppu_gnt !== !cpu_win) begin errors++; $display("FAIL alt_gnt[%0d] got cpu=%b ppu=%b exp cpu=%b", i, bus.cpu_gnt, bus.ppu_gnt, cpu_win); end
                checks++; if (bus.mem_addr !== (cpu_win ? PRG_BASE + 16'h0010 + 16'(i) : CHR_BASE + 16'h0100 + 16'(i))) begin errors++; $display("FAIL alt_addr[%0d] got %h", i, bus.mem_addr); end
            end
            if (i > 0) begin
                checks++; if (bus.cpu_rdata !== e_cpu_rdata || bus.ppu_rdata !== e_ppu_rdata || bus.cpu_rvalid !== !cpu_win) begin errors++; $display("FAIL alt_data[%0d] got %h/%h exp %h/%h", i, bus.cpu_rdata, bus.ppu_rdata, e_cpu_rdata, e_ppu_rdata); end
            end
            advance();
        end
    endtask

    task automatic test_unmapped();
        idle(); bus.cpu_req = 1; bus.cpu_addr = 16'hFFFC; settle(); advance();
        idle(); bus.cpu_req = 1; bus.cpu_addr = 16'h4016; settle();
        checks++; if (bus.cpu_gnt !== 1'b1 || bus.mem_rden !== 1'b0) begin errors++; $display("FAIL unmap_cpu_gnt got gnt=%b rden=%b exp 1/0", bus.cpu_gnt, bus.mem_rden); end
        advance();
        idle(); bus.ppu_req = 1; bus.ppu_addr = 14'h2000; settle();
        checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL unmap_cpu_data got v=%b d=%h exp 1/00", bus.cpu_rvalid, bus.cpu_rdata); end
        checks++; if (bus.ppu_gnt !== 1'b1 || bus.mem_rden !== 1'b0) begin errors++; $display("FAIL unmap_ppu_gnt got gnt=%b rden=%b exp 1/0", bus.ppu_gnt, bus.mem_rden); end
        advance();
        idle(); settle();
        checks++; if (bus.ppu_rvalid !== 1'b1 || bus.ppu_rdata !== 8'h00) begin errors++; $display("FAIL unmap_ppu_data got v=%b d=%h exp 1/00", bus.ppu_rvalid, bus.ppu_rdata); end
        advance();
    endtask

    task automatic test_load();
        logic [7:0] wd [3];
        wd[0] = 8'hAA; wd[1] = 8'hBB; wd[2] = 8'hCC;
        idle(); bus.cpu_req = 1; bus.cpu_addr = 16'h8020; settle();
        checks++; if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL load_pre_gnt got %b exp 1", bus.cpu_gnt); end
        advance();
        bus.load_req = 1; bus.cpu_addr = 16'h8021; settle();
        checks++; if (bus.cpu_gnt !== 1'b0 || bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL load_n got gnt=%b hold=%b exp 0/0", bus.cpu_gnt, bus.cpu_hold); end
        checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== e_cpu_rdata) begin errors++; $display("FAIL load_n_data got v=%b d=%h exp 1/%h", bus.cpu_rvalid, bus.cpu_rdata, e_cpu_rdata); end
        advance();
        bus.ldr_wren = 1; bus.ldr_addr = 16'h0005; bus.ldr_wdata = 8'h99; settle();
        checks++; if (bus.cpu_hold !== 1'b1 || bus.load_ack !== 1'b0 || bus.cpu_gnt !== 1'b0 || bus.mem_wren !== 1'b0) begin errors++; $display("FAIL load_drain got hold=%b ack=%b gnt=%b wren=%b exp 1000", bus.cpu_hold, bus.load_ack, bus.cpu_gnt, bus.mem_wren); end
        advance();
        for (int i = 0; i < 3; i++) begin
            bus.ldr_wren = 1; bus.ldr_addr = 16'(i); bus.ldr_wdata = wd[i]; settle();
            checks++; if (bus.load_ack !== 1'b1 || bus.mem_wren !== 1'b1 || bus.mem_addr !== 16'(i) || bus.mem_wdata !== wd[i] || bus.cpu_gnt !== 1'b0) begin errors++; $display("FAIL load_wr[%0d] got ack=%b wren=%b a=%h d=%h", i, bus.load_ack, bus.mem_wren, bus.mem_addr, bus.mem_wdata); end
            checks++; if (bus.ldr_count !== 16'(i)) begin errors++; $display("FAIL load_cnt[%0d] got %h exp %h", i, bus.ldr_count, 16'(i)); end
            advance();
        end
        bus.ldr_wren = 0; bus.load_req = 0; settle();
        checks++; if (bus.ldr_count !== 16'd3 || bus.load_ack !== 1'b1) begin errors++; $display("FAIL load_cnt3 got cnt=%h ack=%b exp 0003/1", bus.ldr_count, bus.load_ack); end
        advance();
        idle(); bus.cpu_req = 1; bus.cpu_addr = 16'h8001; settle();
        checks++; if (bus.load_ack !== 1'b0 || bus.cpu_hold !== 1'b0 || bus.cpu_gnt !== 1'b1 || bus.mem_addr !== 16'h0001) begin errors++; $display("FAIL load_exit got ack=%b hold=%b gnt=%b a=%h", bus.load_ack, bus.cpu_hold, bus.cpu_gnt, bus.mem_addr); end
        advance();
        idle(); settle();
        checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'hBB) begin errors++; $display("FAIL load_readback got v=%b d=%h exp 1/bb", bus.cpu_rvalid, bus.cpu_rdata); end
        advance();
    endtask

    task automatic test_wren_in_run();
        idle(); bus.ldr_wren = 1; bus.ldr_addr = 16'h0001; bus.ldr_wdata = 8'h55; settle();
        checks++; if (bus.mem_wren !== 1'b0) begin errors++; $display("FAIL run_wren got %b exp 0", bus.mem_wren); end
        advance();
        idle(); bus.cpu_req = 1; bus.cpu_addr = 16'h8001; settle(); advance();
        idle(); settle();
        checks++; if (bus.cpu_rdata !== 8'hBB) begin errors++; $display("FAIL run_wren_mem got %h exp bb", bus.cpu_rdata); end
        advance();
    endtask

    task automatic test_reset_in_load();
        idle(); bus.load_req = 1; settle(); advance();
        settle(); advance();
        bus.ldr_wren = 1; bus.ldr_addr = 16'h0003; bus.ldr_wdata = 8'h5A; settle();
        checks++; if (bus.load_ack !== 1'b1) begin errors++; $display("FAIL rl_ack got %b exp 1", bus.load_ack); end
        advance();
        reset = 1; bus.ldr_addr = 16'h0002; bus.ldr_wdata = 8'h77; settle();
        checks++; if (bus.mem_wren !== 1'b0 || bus.ldr_count !== 16'd1) begin errors++; $display("FAIL rl_suppress got wren=%b cnt=%h exp 0/0001", bus.mem_wren, bus.ldr_count); end
        advance();
        reset = 0; idle(); settle();
        checks++; if (bus.load_ack !== 1'b0 || bus.cpu_hold !== 1'b0 || bus.ldr_count !== 16'h0) begin errors++; $display("FAIL rl_after got ack=%b hold=%b cnt=%h exp 0/0/0000", bus.load_ack, bus.cpu_hold, bus.ldr_count); end
        advance();
        idle(); bus.cpu_req = 1; bus.cpu_addr = 16'h8002; settle(); advance();
        idle(); settle();
        checks++; if (bus.cpu_rdata !== 8'hCC) begin errors++; $display("FAIL rl_mem got %h exp cc", bus.cpu_rdata); end
        advance();
    endtask

    task automatic test_random();
        int load_left = 0;
        for (int c = 0; c < 600; c++) begin
            if (load_left > 0) begin
                bus.load_req = 1; load_left--;
            end else if ($urandom_range(0, 24) == 0) begin
                bus.load_req = 1; load_left = $urandom_range(1, 8);
            end else begin
                bus.load_req = 0;
            end
            bus.cpu_req = 1'($urandom_range(0, 1)); bus.cpu_addr = 16'($urandom);
            bus.ppu_req = 1'($urandom_range(0, 1)); bus.ppu_addr = 14'($urandom);
            bus.ldr_wren = 1'($urandom_range(0, 1)); bus.ldr_addr = 16'($urandom); bus.ldr_wdata = 8'($urandom);
            settle();
            checks++; if (bus.cpu_gnt !== e_cpu_gnt || bus.ppu_gnt !== e_ppu_gnt) begin errors++; $display("FAIL rnd_gnt[%0d] got %b%b exp %b%b", c, bus.cpu_gnt, bus.ppu_gnt, e_cpu_gnt, e_ppu_gnt); end
            checks++; if (bus.mem_rden !== e_rden || bus.mem_wren !== e_wren) begin errors++; $display("FAIL rnd_memctl[%0d] got %b%b exp %b%b", c, bus.mem_rden, bus.mem_wren, e_rden, e_wren); end
            checks++; if (bus.mem_rden === 1'b1 && bus.mem_wren === 1'b1) begin errors++; $display("FAIL rnd_excl[%0d] got rden=1 wren=1 exp not both", c); end
            if (e_rden || e_wren) begin
                checks++; if (bus.mem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", c, bus.mem_addr, e_addr); end
            end
            if (e_wren) begin
                checks++; if (bus.mem_wdata !== e_wdata) begin errors++; $display("FAIL rnd_wdata[%0d] got %h exp %h", c, bus.mem_wdata, e_wdata); end
            end
            checks++; if (bus.cpu_rvalid !== e_cpu_rvalid || bus.cpu_rdata !== e_cpu_rdata) begin errors++; $display("FAIL rnd_cpu_rd[%0d] got %b/%h exp %b/%h", c, bus.cpu_rvalid, bus.cpu_rdata, e_cpu_rvalid, e_cpu_rdata); end
            checks++; if (bus.ppu_rvalid !== e_ppu_rvalid || bus.ppu_rdata !== e_ppu_rdata) begin errors++; $display("FAIL rnd_ppu_rd[%0d] got %b/%h exp %b/%h", c, bus.ppu_rvalid, bus.ppu_rdata, e_ppu_rvalid, e_ppu_rdata); end
            checks++; if (bus.load_ack !== e_ack || bus.cpu_hold !== e_hold) begin errors++; $display("FAIL rnd_mode[%0d] got ack=%b hold=%b exp %b/%b", c, bus.load_ack, bus.cpu_hold, e_ack, e_hold); end
            checks++; if (bus.ldr_count !== e_count) begin errors++; $display("FAIL rnd_count[%0d] got %h exp %h", c, bus.ldr_count, e_count); end
            advance();
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 8'($urandom_range(1, 255));
            ref_mem[a] = mem[a];
        end
        mem[PRG_BASE + 16'h7FFC] = 8'h34;
        ref_mem[PRG_BASE + 16'h7FFC] = 8'h34;
        apply_reset();
        test_reset();
        test_single_read();
        test_alternate();
        test_unmapped();
        test_load();
        test_wren_in_run();
        test_reset_in_load();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
